// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
//   Shared definitions for the ARM core register file and its scoreboard.
//   - calc_aw()     : address width for a given register count
//   - reg_addr_t    : register address at the default geometry
//   - reg_data_t    : register data word at the default geometry
//   - WB_ALU/WB_LD  : write-back port indices (ALU, load/multi-cycle unit)
// ---------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;

  // At least one address bit, even for a degenerate single-register file.
  function automatic int calc_aw(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  localparam int AW_DEF = calc_aw(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0]     reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // Write-back port indices.
  localparam int WB_ALU = 0;
  localparam int WB_LD  = 1;

endpackage : reg_file_pkg

// File: rtl/reg_file_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Pending-write tracker for registers awaiting a load/multi-cycle result.
//   Ports:
//     clk, reset_n  : clock (rising edge), asynchronous active-low reset
//     iss_valid     : decode requests to mark iss_addr pending
//     iss_addr      : destination register of the multi-cycle op
//     clr_en        : load-port write-back this cycle
//     clr_addr      : load-port write-back address
//     busy          : one bit per register, set while a write is outstanding
//     iss_ready     : issue would be accepted this cycle (combinational)
//     pend_cnt      : number of busy registers
// ---------------------------------------------------------------------------
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int PC_IDX   = 15,
  parameter int AW       = calc_aw(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                iss_ready,
  output logic [AW:0]         pend_cnt
);

  logic                accept;
  logic                clr_hit;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    iss_ready = 1'b0;
    set_mask  = '0;
    clr_mask  = '0;
    // The PC slot is never tracked; a pending destination blocks a second
    // issue to it (WAW guard).
    if (int'(iss_addr) < NUM_REGS && int'(iss_addr) != PC_IDX)
      iss_ready = !busy[iss_addr];
    accept = iss_valid && iss_ready;
    if (accept)
      set_mask[iss_addr] = 1'b1;
    if (clr_en && int'(clr_addr) < NUM_REGS)
      clr_mask[clr_addr] = 1'b1;
  end

  // A clear only counts when it drops a bit that is actually set and is not
  // re-set by a same-cycle issue (the issue is newer, so it wins).
  assign clr_hit = |(busy & clr_mask & ~set_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values, independent of statement order.
      busy     <= (busy & ~clr_mask) | set_mask;
      pend_cnt <= pend_cnt + {{AW{1'b0}}, accept} - {{AW{1'b0}}, clr_hit};
    end
  end

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//   Multi-port register file with pending-write scoreboard for the pipelined
//   ARM core. NUM_RD combinational read ports, two write-back ports
//   (port 0 = ALU, port 1 = load/multi-cycle unit). Index PC_IDX is not
//   stored: reads of it return pc_plus8.
//   Ports:
//     clk, reset_n  : clock (rising edge), asynchronous active-low reset
//     pc_plus8      : value returned for reads of PC_IDX
//     rd_addr/data  : read address / data per read port
//     rd_busy       : read register has an outstanding port-1 write
//     we/wa/wd      : write enable / address / data per write port
//     iss_valid     : decode requests to mark iss_addr pending
//     iss_addr      : destination of the multi-cycle op
//     iss_ready     : issue accepted this cycle
//     wr_collision  : registered, both ports wrote one address last cycle
//     pend_cnt      : number of busy registers
//   Configuration macro:
//     WRITE_BYPASS_EN : reads forward same-cycle write data (port 1 over
//                       port 0) and a clearing port-1 write hides rd_busy
//                       in the same cycle. Undefined: reads see stored
//                       values and rd_busy drops one cycle later.
// ---------------------------------------------------------------------------
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 3,
  parameter int PC_IDX   = 15,
  parameter int AW       = calc_aw(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] pc_plus8,
  input  logic [AW-1:0]     rd_addr [NUM_RD],
  output logic [DATA_W-1:0] rd_data [NUM_RD],
  output logic [NUM_RD-1:0] rd_busy,
  input  logic [1:0]        we,
  input  logic [AW-1:0]     wa [2],
  input  logic [DATA_W-1:0] wd [2],
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_ready,
  output logic              wr_collision,
  output logic [AW:0]       pend_cnt
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  // Only in-range, non-PC addresses hold state.
  function automatic logic writable(input logic [AW-1:0] a);
    return (int'(a) < NUM_REGS) && (int'(a) != PC_IDX);
  endfunction

  // -------------------------------------------------------------------------
  // Storage and collision flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the array is reset because the architecture defines every
      // register as 0 after reset; without that requirement leave memories
      // unreset so they map onto RAM.
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
      wr_collision <= 1'b0;
    end else begin
      if (we[WB_ALU] && writable(wa[WB_ALU]))
        regs[wa[WB_ALU]] <= wd[WB_ALU];
      // Issued after the ALU write so the load port wins on a shared address.
      if (we[WB_LD] && writable(wa[WB_LD]))
        regs[wa[WB_LD]] <= wd[WB_LD];
      wr_collision <= we[WB_ALU] && we[WB_LD] &&
                      (wa[WB_ALU] == wa[WB_LD]) && writable(wa[WB_ALU]);
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .PC_IDX   (PC_IDX),
    .AW       (AW)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .clr_en    (we[WB_LD]),
    .clr_addr  (wa[WB_LD]),
    .busy      (busy),
    .iss_ready (iss_ready),
    .pend_cnt  (pend_cnt)
  );

  // -------------------------------------------------------------------------
  // Read muxes
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i] = '0;
      rd_busy[i] = 1'b0;
      if (int'(rd_addr[i]) == PC_IDX) begin
        rd_data[i] = pc_plus8;
      end else if (int'(rd_addr[i]) < NUM_REGS) begin
        rd_data[i] = regs[rd_addr[i]];
        rd_busy[i] = busy[rd_addr[i]];
`ifdef WRITE_BYPASS_EN
        if (we[WB_ALU] && wa[WB_ALU] == rd_addr[i])
          rd_data[i] = wd[WB_ALU];
        if (we[WB_LD] && wa[WB_LD] == rd_addr[i]) begin
          rd_data[i] = wd[WB_LD];
          rd_busy[i] = 1'b0;
        end
`endif
      end
    end
  end

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
//   Self-checking bench for reg_file_sb at default parameters. A reference
//   model holds register contents, busy flags and the collision flag as plain
//   arrays and is advanced once per clock from the driven inputs.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int NRD = 3;
  localparam int PC  = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  reg_data_t   pc_plus8;
  reg_addr_t   rd_addr [NRD];
  reg_data_t   rd_data [NRD];
  logic [2:0]  rd_busy;
  logic [1:0]  we;
  reg_addr_t   wa [2];
  reg_data_t   wd [2];
  logic        iss_valid;
  reg_addr_t   iss_addr;
  logic        iss_ready;
  logic        wr_collision;
  logic [4:0]  pend_cnt;

  reg_file_sb dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_plus8     (pc_plus8),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_busy      (rd_busy),
    .we           (we),
    .wa           (wa),
    .wd           (wd),
    .iss_valid    (iss_valid),
    .iss_addr     (iss_addr),
    .iss_ready    (iss_ready),
    .wr_collision (wr_collision),
    .pend_cnt     (pend_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  reg_data_t m_regs [16];
  bit        m_busy [16];
  bit        m_coll;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_coll = 1'b0;
  endtask

  function automatic int model_pend();
    int n = 0;
    for (int r = 0; r < 16; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  function automatic reg_data_t exp_data(input reg_addr_t a);
    reg_data_t d;
    if (int'(a) == PC) return pc_plus8;
    d = m_regs[a];
`ifdef WRITE_BYPASS_EN
    if (we[0] && wa[0] == a) d = wd[0];
    if (we[1] && wa[1] == a) d = wd[1];
`endif
    return d;
  endfunction

  function automatic logic exp_busy(input reg_addr_t a);
    if (int'(a) == PC) return 1'b0;
`ifdef WRITE_BYPASS_EN
    if (we[1] && wa[1] == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic exp_ready();
    return (int'(iss_addr) != PC) && !m_busy[iss_addr];
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic check_all(input string tag);
    #1;
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("%s_rd_data%0d", tag, p), rd_data[p], exp_data(rd_addr[p]));
      check($sformatf("%s_rd_busy%0d", tag, p), 32'(rd_busy[p]), 32'(exp_busy(rd_addr[p])));
    end
    check({tag, "_iss_ready"}, 32'(iss_ready), 32'(exp_ready()));
    check({tag, "_pend_cnt"}, 32'(pend_cnt), 32'(model_pend()));
    check({tag, "_wr_collision"}, 32'(wr_collision), 32'(m_coll));
  endtask

  // Advance one clock; the model applies the same inputs the DUT sees.
  task automatic tick();
    bit accept;
    accept = iss_valid && exp_ready();
    @(posedge clk);
    if (reset_n) begin
      m_coll = we[0] && we[1] && (wa[0] == wa[1]) && (int'(wa[0]) != PC);
      if (we[0] && int'(wa[0]) != PC) m_regs[wa[0]] = wd[0];
      if (we[1] && int'(wa[1]) != PC) begin
        m_regs[wa[1]] = wd[1];
        m_busy[wa[1]] = 1'b0;
      end
      if (accept) m_busy[iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we        = 2'b00;
    iss_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    pc_plus8  = 32'h108;
    for (int p = 0; p < NRD; p++) rd_addr[p] = '0;
    wa[0] = '0; wa[1] = '0;
    wd[0] = '0; wd[1] = '0;
    iss_addr = '0;
    idle();
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    tick();

    // 1: ALU write, read back on all ports, PC read
    we[0] = 1'b1; wa[0] = 4'd3; wd[0] = 32'hDEADBEEF;
    tick();
    idle();
    for (int p = 0; p < NRD; p++) rd_addr[p] = 4'd3;
    check_all("t1");
    for (int p = 0; p < NRD; p++)
      check($sformatf("t1_r3_port%0d", p), rd_data[p], 32'hDEADBEEF);
    rd_addr[1] = 4'd15;
    #1;
    check("t1_pc_data", rd_data[1], 32'h108);
    check("t1_pc_busy", 32'(rd_busy[1]), 32'd0);
    // PC write is dropped
    we[0] = 1'b1; wa[0] = 4'd15; wd[0] = 32'hFFFF_FFFF;
    tick();
    idle();
    check_all("t1_pcwr");

    // 2: both ports to r5, load port wins, one-cycle collision flag
    we = 2'b11; wa[0] = 4'd5; wa[1] = 4'd5; wd[0] = 32'h11; wd[1] = 32'h22;
    tick();
    idle();
    rd_addr[0] = 4'd5;
    check_all("t2");
    check("t2_r5", rd_data[0], 32'h22);
    check("t2_coll_hi", 32'(wr_collision), 32'd1);
    tick();
    check("t2_coll_lo", 32'(wr_collision), 32'd0);

    // 3: issue r7, re-issue blocked, load write-back clears
    iss_valid = 1'b1; iss_addr = 4'd7;
    check_all("t3_iss");
    tick();
    rd_addr[0] = 4'd7;
    check_all("t3_reiss");
    check("t3_pend1", 32'(pend_cnt), 32'd1);
    check("t3_busy7", 32'(rd_busy[0]), 32'd1);
    check("t3_ready0", 32'(iss_ready), 32'd0);
    tick();
    iss_valid = 1'b0;
    we[1] = 1'b1; wa[1] = 4'd7; wd[1] = 32'h55;
    check_all("t3_clr");
    tick();
    idle();
    check_all("t3_done");
    check("t3_pend0", 32'(pend_cnt), 32'd0);
    check("t3_r7", rd_data[0], 32'h55);

    // 4: same-cycle clear and issue of r2, issue to PC refused
    we[1] = 1'b1; wa[1] = 4'd2; wd[1] = 32'h77;
    iss_valid = 1'b1; iss_addr = 4'd2;
    check_all("t4_both");
    tick();
    idle();
    rd_addr[0] = 4'd2;
    check_all("t4_after");
    check("t4_busy2", 32'(rd_busy[0]), 32'd1);
    check("t4_pend", 32'(pend_cnt), 32'd1);
    iss_valid = 1'b1; iss_addr = 4'd15;
    check_all("t4_pc");
    check("t4_pc_ready", 32'(iss_ready), 32'd0);
    tick();
    idle();

    // 5: reset mid-cycle discards pending issue and write
    iss_valid = 1'b1; iss_addr = 4'd4;
    we[0] = 1'b1; wa[0] = 4'd1; wd[0] = 32'h9;
    rd_addr[0] = 4'd1; rd_addr[1] = 4'd4;
    #2;
    reset_n = 1'b0;
    model_reset();
    check_all("t5_rst");
    check("t5_r1", rd_data[0], 32'd0);
    check("t5_pend", 32'(pend_cnt), 32'd0);
    idle();
    tick();
    reset_n = 1'b1;
    tick();
    check_all("t5_rel");
    check("t5_r1_after", rd_data[0], 32'd0);

    // 6: read r6 while the ALU writes it
    we[0] = 1'b1; wa[0] = 4'd6; wd[0] = 32'h1234;
    tick();
    wd[0] = 32'hA5;
    rd_addr[0] = 4'd6;
    check_all("t6");
`ifdef WRITE_BYPASS_EN
    check("t6_bypass", rd_data[0], 32'hA5);
`else
    check("t6_nobypass", rd_data[0], 32'h1234);
`endif
    tick();
    idle();

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NRD; p++) rd_addr[p] = reg_addr_t'($urandom_range(15));
      we        = 2'($urandom);
      wa[0]     = reg_addr_t'($urandom_range(15));
      wa[1]     = ($urandom_range(3) == 0) ? wa[0] : reg_addr_t'($urandom_range(15));
      wd[0]     = $urandom;
      wd[1]     = $urandom;
      iss_valid = ($urandom_range(2) != 0);
      iss_addr  = reg_addr_t'($urandom_range(15));
      pc_plus8  = $urandom;
      check_all($sformatf("rnd%0d", c));
      tick();
    end
    idle();
    check_all("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_reg_file_sb
